// File: rtl/fft_frame_streamer.sv
// Frame source for the FFT cores: buffers one complex N-point frame and
// replays it as gap-free bursts with frame count, gap, repeat and abort.
module fft_frame_streamer #(
    parameter int DATA_W = 16,
    parameter int LOG2_N = 6,
    parameter int GAP_W  = 8,
    parameter int FCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [LOG2_N-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_re,
    input  logic [DATA_W-1:0] wr_im,
    input  logic              start,
    input  logic              cont_mode,
    input  logic [FCNT_W-1:0] frame_cnt,
    input  logic [GAP_W-1:0]  gap_len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              do_en,
    output logic [DATA_W-1:0] do_re,
    output logic [DATA_W-1:0] do_im,
    output logic              do_first,
    output logic              do_last,
    output logic [FCNT_W-1:0] frame_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Frame buffer, real part in the upper half of each word
    logic [2*DATA_W-1:0] mem [1 << LOG2_N];
    logic [2*DATA_W-1:0] rd_data;

    // Read-side control
    logic [LOG2_N-1:0] rd_addr;
    logic [FCNT_W-1:0] rd_fidx;
    logic              cont_q;
    logic [FCNT_W-1:0] left_q;
    logic [GAP_W-1:0]  gap_q;
    logic [GAP_W-1:0]  gap_cnt;

    // First pipeline stage (alongside the registered buffer read)
    logic              s1_en;
    logic              s1_first;
    logic              s1_last;
    logic              s1_final;
    logic [FCNT_W-1:0] s1_fidx;

    // Output stage companion flag: current sample ends the whole burst
    logic              do_final;

    // Decoded controls
    logic              kill;
    logic              accept;
    logic              rd_issue;
    logic              addr_end;
    logic              frame_end;
    logic              last_frame;
    logic [GAP_W-1:0]  gap_last;
    logic              gap_end;
    logic              burst_end;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_nxt = state;
        if (kill) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (addr_end) begin
                        if (last_frame) begin
                            state_nxt = DONE;
                        end else if (gap_q != '0) begin
                            state_nxt = GAP;
                        end else begin
                            state_nxt = RUN;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == gap_last) begin
                        state_nxt = RUN;
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // FSM outputs; busy also covers the two-stage drain after DONE
    always_comb begin
        kill       = abort && ((state != IDLE) || busy);
        accept     = start && !abort && (state == IDLE) && !busy;
        addr_end   = (rd_addr == LOG2_N'((1 << LOG2_N) - 1));
        last_frame = !cont_q && (left_q == FCNT_W'(1));
        gap_last   = gap_q - GAP_W'(1);
        rd_issue   = (state == RUN) && !kill;
        frame_end  = rd_issue && addr_end;
        gap_end    = (state == GAP) && !kill && (gap_cnt == gap_last);
        burst_end  = do_en && do_last && do_final;
    end

    // Burst bookkeeping: address, frame index, frames left, gap timer
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr <= '0;
            rd_fidx <= '0;
            cont_q  <= 1'b0;
            left_q  <= '0;
            gap_q   <= '0;
            gap_cnt <= '0;
        end else if (accept) begin
            rd_addr <= '0;
            rd_fidx <= '0;
            cont_q  <= cont_mode;
            left_q  <= (frame_cnt == '0) ? FCNT_W'(1) : frame_cnt;
            gap_q   <= gap_len;
            gap_cnt <= '0;
        end else begin
            if (rd_issue) begin
                rd_addr <= rd_addr + LOG2_N'(1);
            end
            if (frame_end && !last_frame) begin
                rd_fidx <= rd_fidx + FCNT_W'(1);
                if (!cont_q) begin
                    left_q <= left_q - FCNT_W'(1);
                end
            end
            if (kill || gap_end) begin
                gap_cnt <= '0;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end
        end
    end

    // Buffer write port, open in every state
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= {wr_re, wr_im};
        end
    end

    // Registered read port; same-address write returns old data
    always_ff @(posedge clk) begin
        if (rd_issue) begin
            rd_data <= mem[rd_addr];
        end
    end

    // Sideband for the sample currently being read
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_en    <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_final <= 1'b0;
            s1_fidx  <= '0;
        end else begin
            s1_en <= rd_issue;
            if (rd_issue) begin
                s1_first <= (rd_addr == '0);
                s1_last  <= addr_end;
                s1_final <= last_frame;
                s1_fidx  <= rd_fidx;
            end
        end
    end

    // Output stage; abort also squashes the sample still in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            do_en     <= 1'b0;
            do_first  <= 1'b0;
            do_last   <= 1'b0;
            do_final  <= 1'b0;
            do_re     <= '0;
            do_im     <= '0;
            frame_idx <= '0;
        end else begin
            do_en    <= s1_en && !kill;
            do_first <= s1_en && s1_first && !kill;
            do_last  <= s1_en && s1_last && !kill;
            do_final <= s1_en && s1_final;
            if (s1_en) begin
                do_re     <= rd_data[2*DATA_W-1:DATA_W];
                do_im     <= rd_data[DATA_W-1:0];
                frame_idx <= s1_fidx;
            end
        end
    end

    // Status: busy from acceptance to the cycle after the final sample
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= burst_end && !kill;
            if (kill) begin
                busy <= 1'b0;
            end else if (accept) begin
                busy <= 1'b1;
            end else if (burst_end) begin
                busy <= 1'b0;
            end
        end
    end

endmodule
